trng_entropy_sampler: RTL and testbench



---
 rtl/trng_entropy_sampler_pkg.sv | 16 +
 rtl/trng_entropy_sampler_vn_debias.sv | 38 +++
 rtl/trng_entropy_sampler.sv | 140 ++++++++++++++
 tb/tb_trng_entropy_sampler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/trng_entropy_sampler_pkg.sv
// Shared types and default sizing for the TRNG entropy sampler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trng_pkg;

  // Von Neumann corrector phase: waiting for the first or the second sample of a pair
  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_e;

  localparam int TRNG_DIV_W     = 8;
  localparam int TRNG_OUT_W     = 8;
  localparam int TRNG_RCT_LIMIT = 32;

endpackage

// File: rtl/trng_entropy_sampler_vn_debias.sv
// Von Neumann debiaser: pairs strobed samples, emits 'a' when the pair differs.
// Latency: bit_out/bit_vld are combinational in the strobe cycle that takes the second sample.
// Backpressure: none; every emitted bit must be consumed in the cycle it is valid.
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic strobe,
  input  logic bit_in,
  output logic bit_out,
  output logic bit_vld
);

  vn_state_e state;
  logic      a;

  // Pair tracking: latch first sample, return to FIRST after the second
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= VN_FIRST;
      a     <= 1'b0;
    end else if (strobe) begin
      if (state == VN_FIRST) begin
        a     <= bit_in;
        state <= VN_SECOND;
      end else begin
        state <= VN_FIRST;
      end
    end
  end

  // A differing pair yields the first sample; equal pairs are discarded
  assign bit_vld = strobe && (state == VN_SECOND) && (a != bit_in);
  assign bit_out = a;

endmodule

// File: rtl/trng_entropy_sampler.sv
// TRNG sampler: sync ring-osc output, sample at div+1 rate, VN debias, pack into OUT_W words.
// Latency: raw_in->s2 2 cycles; completing bit -> out_valid 1 cycle.
// Backpressure: valid/ready; a word completing while the previous is held is dropped (sticky overflow).
// Optional repetition-count health test is built when TRNG_HEALTH_EN is defined.
module trng_entropy_sampler
  import trng_pkg::*;
#(
  parameter int DIV_W     = TRNG_DIV_W,
  parameter int OUT_W     = TRNG_OUT_W,
  parameter int RCT_LIMIT = TRNG_RCT_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             raw_in,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             health_fail
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic             s1, s2;
  logic [DIV_W-1:0] pcnt, div_q, div_cur;
  logic             strobe;
  logic             vn_bit, vn_vld;
  logic [OUT_W-1:0] sr, word;
  logic [CW-1:0]    bcnt;
  logic             word_done, hf_block, load;

  // Two-flop synchroniser for the asynchronous oscillator output
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // div is captured at the start of each period so a change only lands at the next wrap
  assign div_cur = (pcnt == '0) ? div : div_q;
  assign strobe  = en && (pcnt == div_cur);

  // Prescaler: count 0..div, held at 0 while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      div_q <= '0;
    end else begin
      div_q <= div_cur;
      if (!en || strobe) pcnt <= '0;
      else               pcnt <= pcnt + 1'b1;
    end
  end

  trng_vn_debias u_vn (
    .clk     (clk),
    .rst     (rst),
    .clr     (!en),
    .strobe  (strobe),
    .bit_in  (s2),
    .bit_out (vn_bit),
    .bit_vld (vn_vld)
  );

  assign word      = {sr[OUT_W-2:0], vn_bit};
  assign word_done = vn_vld && (bcnt == CW'(OUT_W - 1));
  assign load      = word_done && !hf_block && (!out_valid || out_ready);

  // Shift register and bit count; cleared when sampling is disabled
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (vn_vld) begin
      sr   <= word;
      bcnt <= word_done ? '0 : bcnt + 1'b1;
    end
  end

  // Output register, handshake and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (word_done && !hf_block && out_valid && !out_ready) overflow <= 1'b1;
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam logic [7:0] RCT_MAX = 8'(RCT_LIMIT);

  logic [7:0] rct;
  logic [7:0] rct_nxt;
  logic       rct_prev;

  // Zero count marks "no previous sample" after reset or disable
  always_comb begin
    rct_nxt = rct;
    if (rct == 8'd0 || s2 != rct_prev) rct_nxt = 8'd1;
    else if (rct != RCT_MAX)           rct_nxt = rct + 8'd1;
  end

  // Repetition-count test on strobed samples; failure is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rct         <= 8'd0;
      rct_prev    <= 1'b0;
      health_fail <= 1'b0;
    end else if (!en) begin
      rct <= 8'd0;
    end else if (strobe) begin
      rct      <= rct_nxt;
      rct_prev <= s2;
      if (rct_nxt == RCT_MAX) health_fail <= 1'b1;
    end
  end

  assign hf_block = health_fail;
`else
  logic unused_cfg;
  assign unused_cfg  = (RCT_LIMIT > 0);
  assign hf_block    = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_entropy_sampler.sv
// Directed bench for trng_entropy_sampler (default parameters).
module tb_trng_entropy_sampler;

  localparam int DIV_W = 8;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, raw_in, out_ready;
  logic [DIV_W-1:0] div;
  logic [OUT_W-1:0] out_data;
  logic             out_valid, overflow, health_fail;

  int checks = 0;
  int errors = 0;

  // Per-iteration log of outputs; index t holds the state seen during cycle t+1
  logic       ov_log [256];
  logic [7:0] od_log [256];
  logic       of_log [256];
  logic       hf_log [256];
  int         n_iter;

  always #5 clk = ~clk;

  trng_entropy_sampler dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .raw_in      (raw_in),
    .div         (div),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .health_fail (health_fail)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; raw_in = 1'b0; out_ready = 1'b1; div = '0;
    tick();
    rst = 1'b0;
  endtask

  // Sample j uses pat[j]; raw_in leads en by two cycles to cover the synchroniser.
  // rdy_t: -1 ready always, -2 ready never, otherwise ready only in cycle rdy_t.
  task automatic run_stream(input logic [127:0] pat, input int n, input int d,
                            input int extra, input int rdy_t);
    div    = d[DIV_W-1:0];
    n_iter = 2 + n * (d + 1) + extra;
    for (int t = 0; t < n_iter; t++) begin
      int idx;
      idx = t / (d + 1);
      if (idx >= n) idx = n - 1;
      raw_in    = pat[idx];
      en        = (t >= 2);
      out_ready = (rdy_t == -1) ? 1'b1 : (rdy_t == -2) ? 1'b0 : (t == rdy_t);
      tick();
      ov_log[t] = out_valid;
      od_log[t] = out_data;
      of_log[t] = overflow;
      hf_log[t] = health_fail;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; raw_in = 1'b1; out_ready = 1'b0; div = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health got %b exp 0", health_fail); end
    rst = 1'b0;
  endtask

  task automatic test_alternating;
    int cnt;
    do_reset();
    run_stream(128'hAAAA_AAAA_AAAA_AAAA, 64, 0, 4, -1);
    en = 1'b0;
    cnt = 0;
    for (int t = 0; t < n_iter; t++) if (ov_log[t] === 1'b1) cnt++;
    checks++; if (cnt != 4) begin errors++; $display("FAIL alt_word_count got %0d exp 4", cnt); end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (ov_log[16*k+1] !== 1'b1 || od_log[16*k+1] !== 8'h00) begin
        errors++;
        $display("FAIL alt_word%0d got valid=%b data=%h exp valid=1 data=00", k, ov_log[16*k+1], od_log[16*k+1]);
      end
    end
  endtask

  task automatic test_pattern_div3;
    int cnt;
    do_reset();
    run_stream(128'h9A59, 16, 3, 6, -1);
    en = 1'b0;
    cnt = 0;
    for (int t = 0; t < n_iter; t++) if (ov_log[t] === 1'b1) cnt++;
    checks++; if (cnt != 1) begin errors++; $display("FAIL div3_word_count got %0d exp 1", cnt); end
    checks++; if (ov_log[64] !== 1'b0) begin errors++; $display("FAIL div3_early_valid got %b exp 0", ov_log[64]); end
    checks++;
    if (ov_log[65] !== 1'b1 || od_log[65] !== 8'b1011_0010) begin
      errors++;
      $display("FAIL div3_word got valid=%b data=%h exp valid=1 data=b2", ov_log[65], od_log[65]);
    end
  endtask

  task automatic test_held_one;
    int cnt, first_hf;
    do_reset();
    run_stream({128{1'b1}}, 100, 0, 0, -1);
    en = 1'b0;
    cnt = 0;
    first_hf = -1;
    for (int t = 0; t < n_iter; t++) begin
      if (ov_log[t] === 1'b1) cnt++;
      if (hf_log[t] === 1'b1 && first_hf < 0) first_hf = t;
    end
    checks++; if (cnt != 0) begin errors++; $display("FAIL held_no_valid got %0d words exp 0", cnt); end
`ifdef TRNG_HEALTH_EN
    checks++; if (first_hf != 33) begin errors++; $display("FAIL held_health_time got %0d exp 33", first_hf); end
`else
    checks++; if (first_hf != -1) begin errors++; $display("FAIL held_health_tied got %0d exp -1", first_hf); end
`endif
  endtask

  task automatic test_overflow;
    int bad;
    do_reset();
    run_stream({96'h0, 16'h5555, 16'h9A59}, 32, 0, 3, -2);
    checks++; if (ov_log[16] !== 1'b0) begin errors++; $display("FAIL ovf_early_valid got %b exp 0", ov_log[16]); end
    bad = 0;
    for (int t = 17; t < n_iter; t++) if (ov_log[t] !== 1'b1 || od_log[t] !== 8'hB2) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_hold_stable got %0d bad cycles exp 0", bad); end
    checks++; if (of_log[32] !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", of_log[32]); end
    checks++; if (of_log[33] !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", of_log[33]); end
    en = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_en_off_valid got %b exp 1", out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid got %b exp 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    run_stream({96'h0, 16'h5555, 16'h9A59}, 32, 0, 3, 33);
    en = 1'b0;
    checks++;
    if (ov_log[32] !== 1'b1 || od_log[32] !== 8'hB2) begin
      errors++; $display("FAIL b2b_first got valid=%b data=%h exp valid=1 data=b2", ov_log[32], od_log[32]);
    end
    checks++;
    if (ov_log[33] !== 1'b1 || od_log[33] !== 8'hFF) begin
      errors++; $display("FAIL b2b_second got valid=%b data=%h exp valid=1 data=ff", ov_log[33], od_log[33]);
    end
    checks++;
    if (ov_log[34] !== 1'b1 || od_log[34] !== 8'hFF) begin
      errors++; $display("FAIL b2b_hold got valid=%b data=%h exp valid=1 data=ff", ov_log[34], od_log[34]);
    end
    checks++; if (of_log[n_iter-1] !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow got %b exp 0", of_log[n_iter-1]); end
  endtask

  task automatic test_reset_mid;
    int cnt;
    do_reset();
    run_stream({102'h0, 10'h155, 16'h9A59}, 26, 0, 0, -2);
    checks++;
    if (ov_log[27] !== 1'b1 || od_log[27] !== 8'hB2) begin
      errors++; $display("FAIL mid_pending got valid=%b data=%h exp valid=1 data=b2", ov_log[27], od_log[27]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_data, overflow, health_fail} !== 11'h000) begin
      errors++;
      $display("FAIL mid_reset_outputs got valid=%b data=%h ovf=%b hf=%b exp all 0", out_valid, out_data, overflow, health_fail);
    end
    rst = 1'b0;
    run_stream(128'h9A59, 16, 0, 4, -1);
    en = 1'b0;
    cnt = 0;
    for (int t = 0; t < n_iter; t++) if (ov_log[t] === 1'b1) cnt++;
    checks++; if (cnt != 1) begin errors++; $display("FAIL mid_fresh_count got %0d exp 1", cnt); end
    checks++;
    if (ov_log[17] !== 1'b1 || od_log[17] !== 8'hB2) begin
      errors++; $display("FAIL mid_fresh_word got valid=%b data=%h exp valid=1 data=b2", ov_log[17], od_log[17]);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; raw_in = 1'b0; out_ready = 1'b1; div = '0;
    test_reset();
    test_alternating();
    test_pattern_div3();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_held_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
